// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register bank; `AXIL_REG_SLAVE_ERR_EN enables range check with SLVERR
module axil_reg_slave #(
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W = 4
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic [S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [31:0]                 s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [31:0]                 s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [NUM_REGS*32-1:0]      regs_o,
    output logic [NUM_REGS-1:0]         wr_pulse_o
);
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic aw_held, w_held, aw_hs, w_hs, ar_hs, commit, w_in, r_in;
    logic [S_AXI_ADDR_WIDTH-1:0] aw_addr_q, w_addr;
    logic [31:0] w_data_q, w_data;
    logic [3:0] w_strb_q, w_strb;
    logic [IDX_W-1:0] w_idx, r_idx;
    logic [31:0] regs [NUM_REGS];
    logic unused_ok;
    assign s_axi_awready = !s_axi_areset && w_state == W_IDLE && !aw_held;
    assign s_axi_wready  = !s_axi_areset && w_state == W_IDLE && !w_held;
    assign s_axi_arready = !s_axi_areset && r_state == R_IDLE;
    assign s_axi_bvalid  = w_state == W_RESP;
    assign s_axi_rvalid  = r_state == R_DATA;
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
    assign w_addr = aw_held ? aw_addr_q : s_axi_awaddr;
    assign w_data = w_held ? w_data_q : s_axi_wdata;
    assign w_strb = w_held ? w_strb_q : s_axi_wstrb;
    assign w_idx  = IDX_W'(32'(w_addr[IDX_W+1:2]) % NUM_REGS);
    assign r_idx  = IDX_W'(32'(s_axi_araddr[IDX_W+1:2]) % NUM_REGS);
`ifdef AXIL_REG_SLAVE_ERR_EN
    localparam logic [S_AXI_ADDR_WIDTH-3:0] num_regs_a = (S_AXI_ADDR_WIDTH-2)'(NUM_REGS);
    assign w_in = w_addr[S_AXI_ADDR_WIDTH-1:2] < num_regs_a;
    assign r_in = s_axi_araddr[S_AXI_ADDR_WIDTH-1:2] < num_regs_a;
`else
    assign w_in = 1'b1;
    assign r_in = 1'b1;
`endif
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, w_addr, s_axi_araddr};
    for (genvar i = 0; i < NUM_REGS; i++) assign regs_o[32*i +: 32] = regs[i];
    always_comb begin
        w_next = commit ? W_RESP : (s_axi_bvalid && s_axi_bready) ? W_IDLE : w_state;
        r_next = ar_hs ? R_DATA : (s_axi_rvalid && s_axi_rready) ? R_IDLE : r_state;
    end
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            s_axi_bresp <= 2'b00;
            wr_pulse_o  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            aw_held    <= !commit && (aw_held || aw_hs);
            w_held     <= !commit && (w_held || w_hs);
            wr_pulse_o <= commit && w_in ? NUM_REGS'(1) << w_idx : '0;
            if (aw_hs) aw_addr_q <= s_axi_awaddr;
            if (w_hs) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (commit) s_axi_bresp <= w_in ? 2'b00 : 2'b10;
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < 4; b++)
                    if (commit && w_in && w_idx == IDX_W'(i) && w_strb[b])
                        regs[i][8*b +: 8] <= w_data[8*b +: 8];
        end
    end
    // Sampling regs before the same-edge write commits gives read-before-write ordering
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= 2'b00;
        end else if (ar_hs) begin
            s_axi_rdata <= r_in ? regs[r_idx] : '0;
            s_axi_rresp <= r_in ? 2'b00 : 2'b10;
        end
    end
endmodule
